// File: rtl/pic_fetch_if.sv
// rtl/pic_fetch_if.sv - program memory request/acknowledge bus between fetch stage and program memory
interface pic_fetch_if;
  logic [10:0] pm_addr;
  logic        pm_rd;
  logic [11:0] pm_data;
  logic        pm_ack;

  modport master (output pm_addr, output pm_rd, input pm_data, input pm_ack);
  modport slave  (input pm_addr, input pm_rd, output pm_data, output pm_ack);
endinterface

// File: rtl/pic_fetch.sv
// rtl/pic_fetch.sv - PIC-style fetch stage: PC, two-level stack, redirect and flush
// Optional PIC_FETCH_STK_GUARD_EN adds a stack depth counter with sticky overflow/underflow flags.
module pic_fetch #(
  parameter logic [10:0] RESET_VEC = 11'h7FF,
  parameter logic [11:0] NOP_WORD  = 12'h000
) (
  input  logic              clk,
  input  logic              rst_n,
  pic_fetch_if.master       pm,
  input  logic              stall,
  input  logic [1:0]        pa,
  input  logic              GOTO,
  input  logic              CALL,
  input  logic              RETLW,
  input  logic              skip,
  input  logic              pcl_wr,
  input  logic [7:0]        pcl_din,
  output logic [11:0]       Instr,
  output logic              instr_valid,
  output logic              stk_ovf,
  output logic              stk_unf
);

  logic [10:0] pc;
  logic [10:0] stack1;
  logic [10:0] stack2;
  logic [10:0] pc_inc;
  logic        qual;

  assign pc_inc     = pc + 11'd1;
  assign qual       = instr_valid & ~stall;
  assign pm.pm_addr = pc;
  assign pm.pm_rd   = ~stall;

  // Every redirect flushes the word in flight; skip just steps over the word at pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_VEC;
      stack1      <= 11'd0;
      stack2      <= 11'd0;
      Instr       <= NOP_WORD;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      if (qual && RETLW) begin
        pc          <= stack1;
        stack1      <= stack2;
        Instr       <= NOP_WORD;
        instr_valid <= 1'b0;
      end else if (qual && CALL) begin
        pc          <= {pa, 1'b0, Instr[7:0]};
        stack2      <= stack1;
        stack1      <= pc;
        Instr       <= NOP_WORD;
        instr_valid <= 1'b0;
      end else if (qual && GOTO) begin
        pc          <= {pa, Instr[8:0]};
        Instr       <= NOP_WORD;
        instr_valid <= 1'b0;
      end else if (qual && pcl_wr) begin
        pc          <= {pa, 1'b0, pcl_din};
        Instr       <= NOP_WORD;
        instr_valid <= 1'b0;
      end else if (qual && skip) begin
        pc          <= pc_inc;
        Instr       <= NOP_WORD;
        instr_valid <= 1'b0;
      end else if (pm.pm_ack) begin
        pc          <= pc_inc;
        Instr       <= pm.pm_data;
        instr_valid <= 1'b1;
      end else begin
        Instr       <= NOP_WORD;
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef PIC_FETCH_STK_GUARD_EN
  logic [1:0] depth;
  logic       ovf_q;
  logic       unf_q;

  // Depth saturates at the two physical entries; the flags record any loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= 2'd0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (qual) begin
      if (RETLW) begin
        if (depth == 2'd0) unf_q <= 1'b1;
        else               depth <= depth - 2'd1;
      end else if (CALL) begin
        if (depth == 2'd2) ovf_q <= 1'b1;
        else               depth <= depth + 2'd1;
      end
    end
  end

  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;
`else
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
`endif

endmodule

// File: doc/pic_fetch.md
# pic_fetch

Instruction fetch stage of the 12-bit-instruction PIC-style CPU. Holds the 11-bit program counter and the two-level hardware stack. Reads program memory through a request/acknowledge handshake and presents one instruction word per cycle on `Instr`, which drives the `Decoder` directly. Takes the decoder's flow-control strobes (`GOTO`, `CALL`, `RETLW`) plus the ALU skip/PCL-write results back to redirect fetch and flush the prefetched word.

## Interface
- `RESET_VEC`, 11'h7FF, PC value after reset.
- `NOP_WORD`, 12'h000, word driven on `Instr` for bubbles and flushes.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pm_addr`  out  11  program memory address; equals PC register.
- `pm_rd`  out  1  read request; `= ~stall`.
- `pm_data`  in  12  program word; meaningful only when `pm_ack`=1.
- `pm_ack`  in  1  `pm_data` valid for current `pm_addr` this cycle.
- `stall`  in  1  execute hold (SLEEP, multi-cycle ops); freezes the stage.
- `pa`  in  2  STATUS page bits <6:5>.
- `GOTO`, `CALL`, `RETLW`  in  1 each  decoder strobes for the word on `Instr`.
- `skip`  in  1  skip condition true (BTFSS/BTFSC/DECFSZ/INCFSZ).
- `pcl_wr`, `pcl_din`  in  1, 8  current instruction writes PCL.
- `Instr`  out  12  instruction register to the decoder.
- `instr_valid`  out  1  `Instr` holds a real instruction.
- `stk_ovf`, `stk_unf`  out  1 each  sticky stack error flags (see Configuration).

## Operation
- Registers: `pc[10:0]`, `stack1`, `stack2` (11 b each), `Instr`, `instr_valid`.
- Control inputs are qualified by `instr_valid & ~stall`; otherwise they are ignored.
- Redirect priority (highest first); each sets `Instr<=NOP_WORD`, `instr_valid<=0`, and discards `pm_data` in the same cycle:
  - `RETLW`: `pc<=stack1`, `stack1<=stack2`, `stack2` unchanged.
  - `CALL`: `pc<={pa, 1'b0, Instr[7:0]}`, `stack2<=stack1`, `stack1<=pc`.
  - `GOTO`: `pc<={pa, Instr[8:0]}`.
  - `pcl_wr`: `pc<={pa, 1'b0, pcl_din}`.
  - `skip`: `pc<=pc+1`. This drops the word at `pc`, whether it is acknowledged this cycle or not.
- No redirect, `pm_ack=1`, `stall=0`: `Instr<=pm_data`, `instr_valid<=1`, `pc<=pc+1`.
- No redirect, `pm_ack=0`, `stall=0`: `Instr<=NOP_WORD`, `instr_valid<=0`, `pc` holds.
- `stall=1`: every register holds. `pm_rd=0`; `pm_ack` is ignored.
- Return address pushed by `CALL` is `pc`, which always equals the CALL address +1.
- `pc+1` wraps from 11'h7FF to 11'h000.
- Third nested push silently loses the old `stack2`. Pop on an empty stack returns the stale `stack1`.
- Program memory contract: `pm_addr` is stable while `pm_rd & ~pm_ack`, except on redirect, which aborts the pending read.

## Timing
- Reset (async, while `rst_n`=0): `pc`=`RESET_VEC`, `stack1`=`stack2`=0, `Instr`=`NOP_WORD`, `instr_valid`=0, `stk_ovf`=`stk_unf`=0. `pm_addr`=`RESET_VEC`; `pm_rd` follows `~stall`.
- Fetch latency: a word acknowledged in cycle n appears on `Instr` in cycle n+1. Throughput is one instruction per cycle with zero-wait memory.
- Branch, call, return, PCL write and taken skip each cost exactly one bubble cycle with zero-wait memory.
- Reset asserted mid-fetch or mid-stall: state clears immediately. The first request after release is to `RESET_VEC`.

## Configuration
- `PIC_FETCH_STK_GUARD_EN` defined: adds a 2-bit depth counter (0..2, saturating).
  - `stk_ovf` sets on `CALL` at depth 2.
  - `stk_unf` sets on `RETLW` at depth 0.
  - Both flags are sticky until reset.
- Undefined: no depth counter; `stk_ovf` and `stk_unf` are tied 0.
- Datapath behaviour is identical in both builds.

## Test plan
- Reset release, zero-wait memory with `mem[a]=a[11:0]`: `pm_addr`=7FF, then `Instr`=7FF with `instr_valid`=1. Next cycle `Instr`=000 (wrap), then 001.
- `GOTO` 12'hA25 at address 10, `pa`=2'b01: one bubble (`Instr`=000, `instr_valid`=0), then fetch from 11'h225.
- `CALL` 12'h912 at 050 with `pa`=0, then `RETLW` at 012: PC path 050 → 012 → 051; `stack1`=051 during the subroutine.
- `skip`=1 on word at 020: word at 021 never reaches `Instr` valid; next valid `Instr` is from 022. Repeat with `pm_ack` delayed 2 cycles: same result.
- `stall`=1 for 3 cycles with `Instr`=word 030: `Instr` and `pm_addr` frozen, `pm_rd`=0. On release, execution resumes with no duplicated or lost word.
- With `PIC_FETCH_STK_GUARD_EN`: three nested CALLs set `stk_ovf`=1, and third return goes to the second return address; four RETLWs set `stk_unf`=1. Without the macro, both flags stay 0.
